note_player_ctrl: RTL and testbench

- Responder side of the song_reader note handshake.
- Accepts a note/duration pair on each new_note pulse and drives the note's sine step size to the synthesis datapath.
- Counts the duration in beats and returns a one-cycle note_done pulse so song_reader advances to the next note.
- Sits between song_reader and the sine/codec datapath; contains its own beat generator.

---
 rtl/music_pkg.sv | 8 +
 rtl/freq_rom.sv | 21 ++
 rtl/note_player_ctrl.sv | 80 ++++++++
 tb/tb_note_player_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// music_pkg: shared widths, rest encoding and player state for the song datapath
package music_pkg;
  localparam int NOTE_W = 6;
  localparam int DUR_W = 6;
  localparam int STEP_W = 20;
  localparam logic [NOTE_W-1:0] REST_NOTE = '0;
  typedef enum logic [1:0] {IDLE, PLAYING, DONE} state_e;
endpackage

// File: rtl/freq_rom.sv
// freq_rom: note index -> sine phase increment, equal-tempered from A1 upward
module freq_rom
  import music_pkg::*;
(
  input  logic [NOTE_W-1:0] note,
  output logic [STEP_W-1:0] step_size
);
  // One octave of steps (55 Hz base, 2^20 phase, 48 kHz); higher octaves are left shifts
  localparam logic [11:0] SEMI [12] = '{12'd1202, 12'd1273, 12'd1349, 12'd1429,
                                        12'd1514, 12'd1604, 12'd1699, 12'd1800,
                                        12'd1907, 12'd2021, 12'd2141, 12'd2268};
  logic [NOTE_W-1:0] idx;
  logic [3:0] semi;
  logic [2:0] oct;
  always_comb begin
    idx = note - 1'b1;
    semi = 4'(idx % 12);
    oct = 3'(idx / 12);
    step_size = (note == REST_NOTE) ? '0 : STEP_W'(SEMI[semi]) << oct;
  end
endmodule

// File: rtl/note_player_ctrl.sv
// note_player_ctrl: times each note from song_reader in beats and drives the
// sine step size, returning a one-cycle note_done when the note has elapsed.
module note_player_ctrl
  import music_pkg::*;
#(
  parameter int BEAT_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              new_note,
  input  logic [NOTE_W-1:0] note,
  input  logic [DUR_W-1:0]  duration,
  input  logic              song_done,
  output logic [STEP_W-1:0] step_size,
  output logic              note_active,
  output logic              note_done,
  output logic              beat
);
  localparam int CNT_W = $clog2(BEAT_DIV);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [STEP_W-1:0] step_q, step_d, rom_step;
  logic active_q, active_d, done_q, done_d, run;

  freq_rom u_rom (.note, .step_size(rom_step));

  assign run = play && state_q == PLAYING;
  assign beat = run && cnt_q == CNT_W'(BEAT_DIV - 1);
  assign step_size = play ? step_q : '0;
  assign note_active = active_q;
  assign note_done = done_q;

  // A zero-length note arriving during DONE detours through PLAYING so note_done never repeats back to back
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    step_d = step_q;
    if (song_done) begin
      state_d = IDLE;
      cnt_d = '0;
      rem_d = '0;
      step_d = '0;
    end else if (new_note) begin
      state_d = (duration == '0 && state_q != DONE) ? DONE : PLAYING;
      cnt_d = '0;
      rem_d = duration;
      step_d = (duration == '0) ? '0 : rom_step;
    end else if (state_q == PLAYING) begin
      cnt_d = beat ? '0 : run ? cnt_q + 1'b1 : cnt_q;
      rem_d = (beat && rem_q != '0) ? rem_q - 1'b1 : rem_q;
      state_d = (rem_d == '0) ? DONE : PLAYING;
      step_d = (rem_d == '0) ? '0 : step_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    active_d = state_d == PLAYING;
    done_d = state_d == DONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      step_q <= '0;
      active_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      step_q <= step_d;
      active_q <= active_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_note_player_ctrl.sv
// tb_note_player_ctrl: directed test-plan scenarios plus random traffic, scored
// against a countdown-of-run-cycles model of each note.
module tb_note_player_ctrl;
  import music_pkg::*;
  localparam int DIV = 4;
  localparam int SEMI [12] = '{1202, 1273, 1349, 1429, 1514, 1604, 1699, 1800, 1907, 2021, 2141, 2268};
  localparam int M_IDLE = 0, M_PLAY = 1, M_DONE = 2;

  logic clk = 1'b0, reset = 1'b0, play = 1'b0, new_note = 1'b0, song_done = 1'b0;
  logic [NOTE_W-1:0] note = '0;
  logic [DUR_W-1:0] duration = '0;
  logic [STEP_W-1:0] step_size;
  logic note_active, note_done, beat;

  typedef struct {
    logic [STEP_W-1:0] step;
    logic active;
    logic done;
    logic beat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int done_q[$];
  int checks = 0, errors = 0, cyc_n = 0;
  int m_st = M_IDLE, m_ticks = 0;
  logic [STEP_W-1:0] m_step = '0;

  note_player_ctrl #(.BEAT_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .play(play), .new_note(new_note), .note(note),
    .duration(duration), .song_done(song_done), .step_size(step_size),
    .note_active(note_active), .note_done(note_done), .beat(beat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [STEP_W-1:0] ref_step(input int n);
    if (n == 0) return '0;
    return STEP_W'(SEMI[(n - 1) % 12] * (2 ** ((n - 1) / 12)));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
    end
  endtask

  // Model: a note is D*DIV running cycles; a beat falls where one cycle of a beat remains
  task automatic cyc(input logic p, input logic nn, input int n, input int d, input logic sd);
    exp_t e;
    @(posedge clk);
    #1;
    play = p;
    new_note = nn;
    note = NOTE_W'(n);
    duration = DUR_W'(d);
    song_done = sd;
    e.step = (p && m_st == M_PLAY) ? m_step : '0;
    e.active = m_st == M_PLAY;
    e.done = m_st == M_DONE;
    e.beat = m_st == M_PLAY && p && m_ticks % DIV == 1;
    exp_q.push_back(e);
    if (sd) m_st = M_IDLE;
    else if (nn) begin
      m_st = (d == 0) ? M_DONE : M_PLAY;
      m_ticks = d * DIV;
      m_step = (d == 0) ? '0 : ref_step(n);
    end else if (m_st == M_PLAY && p) begin
      m_ticks--;
      if (m_ticks == 0) m_st = M_DONE;
    end else if (m_st == M_DONE) m_st = M_IDLE;
    if (m_st == M_DONE) done_q.push_back(cyc_n + 1);
  endtask

  task automatic idle(input int k, input logic p);
    for (int i = 0; i < k; i++) cyc(p, 1'b0, 0, 0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (reset && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("step_size", 32'(step_size), 32'(mon_e.step));
      check("note_active", 32'(note_active), 32'(mon_e.active));
      check("beat", 32'(beat), 32'(mon_e.beat));
      check("note_done", 32'(note_done), 32'(mon_e.done));
      if (done_q.size() > 0 && done_q[0] == cyc_n) begin
        void'(done_q.pop_front());
        check("note_done_due", 32'(note_done), 32'd1);
      end else check("note_done_spurious", 32'(note_done), 32'd0);
    end
  end

  initial begin
    logic p, nn, sd;
    int n, d;
    play = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_step", 32'(step_size), 32'd0);
    check("rst_active", 32'(note_active), 32'd0);
    check("rst_done", 32'(note_done), 32'd0);
    check("rst_beat", 32'(beat), 32'd0);
    @(negedge clk) reset = 1'b1;
    idle(3, 1'b1);
    cyc(1'b1, 1'b1, 10, 3, 1'b0);
    idle(15, 1'b1);
    cyc(1'b1, 1'b1, 0, 2, 1'b0);
    idle(11, 1'b1);
    cyc(1'b1, 1'b1, 5, 0, 1'b0);
    idle(3, 1'b1);
    cyc(1'b1, 1'b1, 7, 4, 1'b0);
    idle(4, 1'b1);
    idle(10, 1'b0);
    idle(16, 1'b1);
    cyc(1'b1, 1'b1, 12, 5, 1'b0);
    idle(5, 1'b1);
    cyc(1'b1, 1'b1, 20, 1, 1'b0);
    idle(8, 1'b1);
    cyc(1'b1, 1'b1, 30, 3, 1'b0);
    idle(3, 1'b1);
    cyc(1'b1, 1'b1, 40, 2, 1'b1);
    idle(10, 1'b1);
    cyc(1'b0, 1'b1, 63, 1, 1'b0);
    idle(3, 1'b0);
    idle(8, 1'b1);
    cyc(1'b1, 1'b1, 9, 4, 1'b0);
    idle(5, 1'b1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_step", 32'(step_size), 32'd0);
    check("mid_rst_active", 32'(note_active), 32'd0);
    check("mid_rst_done", 32'(note_done), 32'd0);
    check("mid_rst_beat", 32'(beat), 32'd0);
    exp_q.delete();
    done_q.delete();
    m_st = M_IDLE;
    m_ticks = 0;
    m_step = '0;
    @(negedge clk) reset = 1'b1;
    idle(20, 1'b1);
    for (int i = 0; i < 800; i++) begin
      p = $urandom_range(9) != 0;
      nn = (m_st != M_PLAY) ? $urandom_range(2) == 0 : $urandom_range(29) == 0;
      sd = $urandom_range(59) == 0;
      n = $urandom_range(63);
      d = $urandom_range(5);
      if (m_st == M_DONE && d == 0) d = 1;
      cyc(p, nn, n, d, sd);
    end
    cyc(1'b1, 1'b0, 0, 0, 1'b1);
    idle(5, 1'b1);
    @(posedge clk);
    #1;
    check("pending_done", 32'(done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
